aes_inv_sched: RTL and testbench

- Controller that shares one aes_inv_cipher_top core between NREQ requesters.
- Arbitrates round-robin, sequences the core's kld/ld/done protocol and caches the last expanded key so that back-to-back same-key requests skip key expansion.
- Returns each plaintext on a valid/ready response channel tagged with the requester id.
- Sits between the requester fabric and a single inverse-cipher instance.

---
 rtl/aes_inv_sched.sv | 181 ++++++++++++++++++
 tb/tb_aes_inv_sched.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_sched.sv
// Round-robin scheduler sharing one aes_inv_cipher_top core, with a last-key cache.
// Optional BUSY watchdog is compiled in by defining AES_SCHED_WATCHDOG_EN.
module aes_inv_sched #(
  parameter int NREQ      = 2,
  parameter int KEY_WAIT  = 12,
  parameter int TO_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*128-1:0]     req_key,
  input  logic [NREQ*128-1:0]     req_text,
  input  logic                    key_flush,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [127:0]            rsp_text,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic                    rsp_err,
  output logic                    core_kld,
  output logic                    core_ld,
  output logic [127:0]            core_key,
  output logic [127:0]            core_text_in,
  input  logic                    core_done,
  input  logic [127:0]            core_text_out
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(KEY_WAIT + 2);

  if (NREQ < 2 || NREQ > 8 || TO_CYCLES < 1 || KEY_WAIT < 0) begin : g_bad_cfg
    $error("aes_inv_sched: unsupported parameters");
  end

  typedef enum logic [2:0] {
    IDLE, KLOAD, KWAIT, START, BUSY, RESP
  } state_e;

  state_e         state_q;
  logic [IW-1:0]  last_q, id_q, gnt, idx;
  logic           gnt_vld, gnt_hit;
  logic [127:0]   gnt_key, gnt_text;
  logic [127:0]   key_q, text_q, cache_key_q, rsp_text_q;
  logic           cache_vld_q, kld_q, ld_q, rsp_valid_q;
  logic [CW-1:0]  kcnt_q;

`ifdef AES_SCHED_WATCHDOG_EN
  localparam int TW = $clog2(TO_CYCLES + 1);
  logic [TW-1:0]  wcnt_q;
  logic           err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Lowest offset from last_q+1 wins, so scan offsets downward.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = IW'((int'(last_q) + i) % NREQ);
      if (req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
  end

  assign gnt_key  = req_key[128*int'(gnt) +: 128];
  assign gnt_text = req_text[128*int'(gnt) +: 128];
  assign gnt_hit  = cache_vld_q & ~key_flush &
                    (cache_key_q == gnt_key);

  always_comb begin
    req_ready = '0;
    if (rst && state_q == IDLE && gnt_vld)
      req_ready[gnt] = 1'b1;
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_text     = rsp_text_q;
  assign rsp_id       = id_q;
  assign core_kld     = kld_q;
  assign core_ld      = ld_q;
  assign core_key     = key_q;
  assign core_text_in = text_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= '0;
      id_q        <= '0;
      key_q       <= '0;
      text_q      <= '0;
      cache_key_q <= '0;
      cache_vld_q <= 1'b0;
      rsp_text_q  <= '0;
      rsp_valid_q <= 1'b0;
      kld_q       <= 1'b0;
      ld_q        <= 1'b0;
      kcnt_q      <= '0;
`ifdef AES_SCHED_WATCHDOG_EN
      wcnt_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      kld_q <= 1'b0;
      ld_q  <= 1'b0;
      if (key_flush)
        cache_vld_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            id_q   <= gnt;
            last_q <= gnt;
            key_q  <= gnt_key;
            text_q <= gnt_text;
            if (gnt_hit) begin
              state_q <= START;
              ld_q    <= 1'b1;
            end else begin
              state_q <= KLOAD;
              kld_q   <= 1'b1;
            end
          end
        end
        KLOAD: begin
          cache_key_q <= key_q;
          if (!key_flush)
            cache_vld_q <= 1'b1;
          kcnt_q <= '0;
          if (KEY_WAIT == 0) begin
            state_q <= START;
            ld_q    <= 1'b1;
          end else begin
            state_q <= KWAIT;
          end
        end
        KWAIT: begin
          if (kcnt_q == CW'(KEY_WAIT - 1)) begin
            state_q <= START;
            ld_q    <= 1'b1;
          end else begin
            kcnt_q <= kcnt_q + 1'b1;
          end
        end
        START: begin
          state_q <= BUSY;
`ifdef AES_SCHED_WATCHDOG_EN
          wcnt_q  <= '0;
`endif
        end
        BUSY: begin
          if (core_done) begin
            rsp_text_q  <= core_text_out;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
`ifdef AES_SCHED_WATCHDOG_EN
            err_q       <= 1'b0;
          end else if (wcnt_q == TW'(TO_CYCLES - 1)) begin
            rsp_text_q  <= '0;
            rsp_valid_q <= 1'b1;
            err_q       <= 1'b1;
            cache_vld_q <= 1'b0;
            state_q     <= RESP;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_inv_sched.sv
// Randomised bench for aes_inv_sched with a stub core and a transaction-level model.
// Define AES_SCHED_WATCHDOG_EN to also exercise the watchdog path.
module tb_aes_inv_sched;
  localparam int NREQ = 2;
  localparam int KW   = 12;
  localparam int TO   = 64;
  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*128-1:0]  req_key = '0;
  logic [NREQ*128-1:0]  req_text = '0;
  logic                 key_flush = 1'b0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [127:0]         rsp_text;
  logic [0:0]           rsp_id;
  logic                 rsp_err;
  logic                 core_kld, core_ld;
  logic [127:0]         core_key, core_text_in;
  logic                 core_done = 1'b0;
  logic [127:0]         core_text_out = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  aes_inv_sched #(.NREQ(NREQ), .KEY_WAIT(KW), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_text(req_text),
    .key_flush(key_flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_text(rsp_text), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .core_kld(core_kld), .core_ld(core_ld),
    .core_key(core_key), .core_text_in(core_text_in),
    .core_done(core_done), .core_text_out(core_text_out)
  );

  // Stub core: FIPS-197 vector decrypts correctly, anything else maps reversibly.
  function automatic logic [127:0] plain(input logic [127:0] k, input logic [127:0] t);
    if (k == FK && t == FC) return FP;
    return t ^ {k[63:0], k[127:64]} ^ {4{32'h5a3c_96e1}};
  endfunction

  logic [127:0] skey = '0, stext = '0;
  int  pend = 0;
  int  core_lat = 3;
  bit  core_hang = 1'b0;

  always @(posedge clk) begin
    core_done <= 1'b0;
    if (core_kld) skey <= core_key;
    if (core_ld) begin
      stext <= core_text_in;
      pend  <= core_lat;
    end else if (pend > 0) begin
      if (pend == 1 && !core_hang) begin
        core_done     <= 1'b1;
        core_text_out <= plain(skey, stext);
      end
      pend <= pend - 1;
    end
  end

  int cyc = 0, acc_cnt = 0, acc_cyc = 0, acc_id = 0;
  int kld_cnt = 0, ld_cnt = 0, ld_cyc = 0;
  int done_cyc = 0, rsp_cyc = 0, rsp_cnt = 0;
  bit rv_prev = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i] && req_ready[i]) begin
        acc_cnt++; acc_cyc = cyc; acc_id = i;
      end
    if (core_kld) kld_cnt++;
    if (core_ld) begin ld_cnt++; ld_cyc = cyc; end
    if (core_done) done_cyc = cyc;
    if (rsp_valid && !rv_prev) rsp_cyc = cyc;
    if (rsp_valid && rsp_ready) rsp_cnt++;
    rv_prev = rsp_valid;
    cyc++;
  end

  // Model state: cache contents and round-robin pointer.
  bit           m_vld = 1'b0;
  logic [127:0] m_key = '0;
  int           m_last = 0;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_one(input int id, input logic [127:0] k, input logic [127:0] t,
                         input bit flush, output logic [127:0] rt, output int rid,
                         output bit rerr);
    int a0;
    a0 = acc_cnt;
    @(negedge clk);
    req_valid[id] = 1'b1;
    req_key[id*128 +: 128]  = k;
    req_text[id*128 +: 128] = t;
    key_flush = flush;
    for (int n = 0; n < 50 && acc_cnt == a0; n++) @(negedge clk);
    req_valid[id] = 1'b0;
    key_flush = 1'b0;
    if (acc_cnt == a0) begin
      tests++; fails++;
      $display("FAIL accept_timeout req %0d never accepted", id);
    end
    for (int n = 0; n < 3000 && !rsp_valid; n++) @(negedge clk);
    if (!rsp_valid) begin
      tests++; fails++;
      $display("FAIL rsp_timeout rsp_valid never rose for req %0d", id);
    end
    rt = rsp_text; rid = int'(rsp_id); rerr = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = '1;
    #3;
    tests++;
    if ({req_ready, rsp_valid, rsp_err, core_kld, core_ld} !== '0 ||
        rsp_text !== '0 || rsp_id !== '0 || core_key !== '0 || core_text_in !== '0) begin
      fails++;
      $display("FAIL reset_outputs got rdy=%b rv=%b kld=%b ld=%b key=%h txt=%h want all 0",
               req_ready, rsp_valid, core_kld, core_ld, core_key, core_text_in);
    end
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    m_vld = 1'b0; m_last = 0;
    @(negedge clk);
  endtask

  task automatic test_fips(input string nm);
    logic [127:0] rt; int rid; bit er; int k0; bit hit;
    hit = m_vld && m_key == FK;
    k0 = kld_cnt;
    run_one(0, FK, FC, 1'b0, rt, rid, er);
    tests++;
    if (rt !== FP) begin fails++; $display("FAIL %s_text got %h want %h", nm, rt, FP); end
    tests++;
    if (rid != 0) begin fails++; $display("FAIL %s_id got %0d want 0", nm, rid); end
    tests++;
    if (kld_cnt - k0 != (hit ? 0 : 1)) begin
      fails++; $display("FAIL %s_kld got %0d want %0d", nm, kld_cnt - k0, hit ? 0 : 1);
    end
    tests++;
    if (ld_cyc - acc_cyc != (hit ? 1 : KW + 2)) begin
      fails++; $display("FAIL %s_ld_lat got %0d want %0d", nm, ld_cyc - acc_cyc, hit ? 1 : KW + 2);
    end
    tests++;
    if (rsp_cyc - done_cyc != 1) begin
      fails++; $display("FAIL %s_rsp_lat got %0d want 1", nm, rsp_cyc - done_cyc);
    end
    m_vld = 1'b1; m_key = FK; m_last = 0;
  endtask

  task automatic test_random();
    logic [127:0] k, t, rt; int id, rid, k0; bit er, fl, hit;
    for (int it = 0; it < 10; it++) begin
      id = $urandom_range(0, NREQ - 1);
      k  = ($urandom_range(0, 1) == 1) ? m_key : rnd128();
      t  = rnd128();
      fl = ($urandom_range(0, 3) == 0);
      core_lat = $urandom_range(1, 8);
      hit = m_vld && m_key == k && !fl;
      k0 = kld_cnt;
      run_one(id, k, t, fl, rt, rid, er);
      tests++;
      if (rt !== plain(k, t) || rid != id || er !== 1'b0) begin
        fails++;
        $display("FAIL rand_rsp[%0d] got %h/%0d/%b want %h/%0d/0", it, rt, rid, er, plain(k, t), id);
      end
      tests++;
      if (kld_cnt - k0 != (hit ? 0 : 1) || ld_cyc - acc_cyc != (hit ? 1 : KW + 2)) begin
        fails++;
        $display("FAIL rand_lat[%0d] got kld=%0d ld=%0d want kld=%0d ld=%0d", it,
                 kld_cnt - k0, ld_cyc - acc_cyc, hit ? 0 : 1, hit ? 1 : KW + 2);
      end
      m_vld = 1'b1; m_key = k; m_last = id;
    end
  endtask

  task automatic test_round_robin();
    logic [127:0] k; logic [127:0] t [NREQ]; int e, k0; bit hit;
    k = rnd128();
    hit = m_vld && m_key == k;
    k0 = kld_cnt;
    core_lat = 2;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      t[i] = rnd128();
      req_key[i*128 +: 128]  = k;
      req_text[i*128 +: 128] = t[i];
    end
    req_valid = '1;
    for (int r = 0; r < 4; r++) begin
      e = (m_last + 1) % NREQ;
      for (int n = 0; n < 500 && !rsp_valid; n++) @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b1 || int'(rsp_id) != e || rsp_text !== plain(k, t[e])) begin
        fails++;
        $display("FAIL rr_rsp[%0d] got v=%b id=%0d txt=%h want id=%0d txt=%h",
                 r, rsp_valid, rsp_id, rsp_text, e, plain(k, t[e]));
      end
      m_last = e;
      if (r == 3) req_valid = '0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    tests++;
    if (kld_cnt - k0 != (hit ? 0 : 1)) begin
      fails++; $display("FAIL rr_kld got %0d want %0d", kld_cnt - k0, hit ? 0 : 1);
    end
    m_vld = 1'b1; m_key = k;
  endtask

  task automatic test_back_pressure();
    logic [127:0] k, t, want; int a0, r0; bit bad_v, bad_t, bad_r;
    k = rnd128(); t = rnd128(); want = plain(k, t);
    a0 = acc_cnt;
    @(negedge clk);
    req_key[127:0] = k; req_text[127:0] = t; req_valid = 2'b01;
    for (int n = 0; n < 50 && acc_cnt == a0; n++) @(negedge clk);
    req_valid = '0;
    for (int n = 0; n < 500 && !rsp_valid; n++) @(negedge clk);
    req_valid = 2'b10;
    bad_v = 0; bad_t = 0; bad_r = 0;
    for (int c = 0; c < 20; c++) begin
      tests++;
      if (rsp_valid !== 1'b1) begin
        fails++; bad_v = 1; $display("FAIL bp_valid[%0d] got %b want 1", c, rsp_valid);
      end
      tests++;
      if (rsp_text !== want) begin
        fails++; bad_t = 1; $display("FAIL bp_text[%0d] got %h want %h", c, rsp_text, want);
      end
      tests++;
      if (req_ready !== '0) begin
        fails++; bad_r = 1; $display("FAIL bp_ready[%0d] got %b want 00", c, req_ready);
      end
      @(negedge clk);
    end
    req_valid = '0;
    r0 = rsp_cnt;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (rsp_cnt - r0 != 1 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL bp_single got %0d rsp v=%b want 1 rsp v=0", rsp_cnt - r0, rsp_valid);
    end
    m_vld = 1'b1; m_key = k; m_last = 0;
  endtask

  task automatic test_flush_reset();
    logic [127:0] k, rt; int rid, k0, a0, l0; bit er;
    k = m_key;
    @(negedge clk);
    key_flush = 1'b1;
    @(negedge clk);
    key_flush = 1'b0;
    k0 = kld_cnt;
    run_one(1, k, rnd128(), 1'b0, rt, rid, er);
    tests++;
    if (kld_cnt - k0 != 1 || ld_cyc - acc_cyc != KW + 2) begin
      fails++; $display("FAIL flush_idle got kld=%0d ld=%0d want 1/%0d", kld_cnt - k0, ld_cyc - acc_cyc, KW + 2);
    end
    k0 = kld_cnt;
    run_one(0, k, rnd128(), 1'b1, rt, rid, er);
    tests++;
    if (kld_cnt - k0 != 1) begin
      fails++; $display("FAIL flush_accept got kld=%0d want 1", kld_cnt - k0);
    end
    k0 = kld_cnt;
    run_one(1, k, rnd128(), 1'b0, rt, rid, er);
    tests++;
    if (kld_cnt - k0 != 0 || ld_cyc - acc_cyc != 1) begin
      fails++; $display("FAIL flush_rehit got kld=%0d ld=%0d want 0/1", kld_cnt - k0, ld_cyc - acc_cyc);
    end
    m_vld = 1'b1; m_key = k; m_last = 1;
    // Abandon a job mid-BUSY; its late core_done must not produce a response.
    core_lat = 30;
    a0 = acc_cnt; l0 = ld_cnt;
    @(negedge clk);
    req_key[127:0] = rnd128(); req_text[127:0] = rnd128(); req_valid = 2'b01;
    for (int n = 0; n < 50 && acc_cnt == a0; n++) @(negedge clk);
    req_valid = '0;
    for (int n = 0; n < 100 && ld_cnt == l0; n++) @(negedge clk);
    @(negedge clk); @(negedge clk);
    req_valid = '1;
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({req_ready, rsp_valid, rsp_err, core_kld, core_ld} !== '0 ||
        rsp_text !== '0 || rsp_id !== '0 || core_key !== '0 || core_text_in !== '0) begin
      fails++;
      $display("FAIL busy_reset got rdy=%b rv=%b kld=%b ld=%b key=%h txt=%h want all 0",
               req_ready, rsp_valid, core_kld, core_ld, core_key, core_text_in);
    end
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    m_vld = 1'b0; m_last = 0;
    a0 = rsp_cnt;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rsp_valid) a0 = -1;
    end
    tests++;
    if (a0 == -1) begin fails++; $display("FAIL busy_reset_norsp got rsp_valid=1 want 0"); end
    core_lat = 3;
    k0 = kld_cnt;
    run_one(0, k, rnd128(), 1'b0, rt, rid, er);
    tests++;
    if (kld_cnt - k0 != 1) begin
      fails++; $display("FAIL reset_miss got kld=%0d want 1", kld_cnt - k0);
    end
    m_vld = 1'b1; m_key = k;
  endtask

`ifdef AES_SCHED_WATCHDOG_EN
  task automatic test_watchdog();
    logic [127:0] k, rt; int rid, k0; bit er;
    k = m_key;
    core_hang = 1'b1;
    run_one(1, k, rnd128(), 1'b0, rt, rid, er);
    core_hang = 1'b0;
    tests++;
    if (er !== 1'b1 || rt !== '0 || rsp_cyc - ld_cyc != TO + 1) begin
      fails++;
      $display("FAIL wd_rsp got err=%b txt=%h lat=%0d want 1/0/%0d", er, rt, rsp_cyc - ld_cyc, TO + 1);
    end
    k0 = kld_cnt;
    run_one(0, k, rnd128(), 1'b0, rt, rid, er);
    tests++;
    if (kld_cnt - k0 != 1 || er !== 1'b0) begin
      fails++; $display("FAIL wd_reload got kld=%0d err=%b want 1/0", kld_cnt - k0, er);
    end
    m_vld = 1'b1; m_key = k; m_last = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_fips("fips");
    test_fips("hit");
    test_round_robin();
    test_back_pressure();
    test_random();
    test_flush_reset();
`ifdef AES_SCHED_WATCHDOG_EN
    test_watchdog();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end
endmodule
